avalon_verin_ram_arbiter: RTL and testbench



---
 rtl/avalon_verin_ram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_avalon_verin_ram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_verin_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : avalon_verin_ram_arbiter
// Description : Two-master round-robin Avalon-MM arbiter in front of the
//               verin single-port on-chip RAM. Fixed 1-cycle read latency,
//               out-of-range and read+write protocol errors flagged per master.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_verin_ram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 5120
) (
    input  logic                clk,
    input  logic                reset,
    // master 0 (Nios data master)
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    output logic                m0_err,
    // master 1 (verin sample logger)
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic                m1_err,
    // error flag clear, applies to both masters
    input  logic                err_clear,
    // RAM side
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    input  logic [DATA_W-1:0]   ram_readdata
);

    localparam logic [ADDR_W:0] c_depth = DEPTH[ADDR_W:0];

    logic                w_req0;
    logic                w_req1;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_any_gnt;
    logic                w_rd;
    logic                w_wr;
    logic                w_in_range;
    logic                w_set_err0;
    logic                w_set_err1;
    logic                w_rdv0;
    logic                w_rdv1;
    logic [DATA_W-1:0]   w_resp_data;

    logic                r_last_grant;
    logic                r_tag_valid;
    logic                r_tag_id;
    logic                r_tag_oor;
    logic [DATA_W-1:0]   r_hold0;
    logic [DATA_W-1:0]   r_hold1;
    logic                r_err0;
    logic                r_err1;

    // Round-robin grant; nothing is accepted while reset is asserted
    always_comb begin
        w_req0    = m0_read | m0_write;
        w_req1    = m1_read | m1_write;
        w_gnt0    = ~reset & w_req0 & (~w_req1 | r_last_grant);
        w_gnt1    = ~reset & w_req1 & (~w_req0 | ~r_last_grant);
        w_any_gnt = w_gnt0 | w_gnt1;
    end

    // RAM-side mux: winner's request, master 0 inputs when idle
    always_comb begin
        ram_address    = w_gnt1 ? m1_address    : m0_address;
        ram_byteenable = w_gnt1 ? m1_byteenable : m0_byteenable;
        ram_writedata  = w_gnt1 ? m1_writedata  : m0_writedata;
        w_rd           = w_gnt1 ? m1_read       : m0_read;
        w_wr           = w_gnt1 ? m1_write      : m0_write;
        w_in_range     = {1'b0, ram_address} < c_depth;
        ram_chipselect = w_any_gnt & w_in_range;
        ram_write      = w_any_gnt & w_in_range & w_wr;
        m0_waitrequest = w_req0 & ~w_gnt0;
        m1_waitrequest = w_req1 & ~w_gnt1;
        // out-of-range access or simultaneous read+write is an error
        w_set_err0     = w_gnt0 & (~w_in_range | (m0_read & m0_write));
        w_set_err1     = w_gnt1 & (~w_in_range | (m1_read & m1_write));
    end

    // Arbitration history and read tag (read dropped when write is also set)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_tag_valid  <= 1'b0;
            r_tag_id     <= 1'b0;
            r_tag_oor    <= 1'b0;
        end else begin
            if (w_any_gnt) begin
                r_last_grant <= w_gnt1;
            end
            r_tag_valid <= w_any_gnt & w_rd & ~w_wr;
            r_tag_id    <= w_gnt1;
            r_tag_oor   <= ~w_in_range;
        end
    end

    // Response steering: live RAM data on the valid pulse, held value otherwise
    always_comb begin
        w_rdv0           = ~reset & r_tag_valid & ~r_tag_id;
        w_rdv1           = ~reset & r_tag_valid &  r_tag_id;
        w_resp_data      = r_tag_oor ? '0 : ram_readdata;
        m0_readdatavalid = w_rdv0;
        m1_readdatavalid = w_rdv1;
        m0_readdata      = w_rdv0 ? w_resp_data : r_hold0;
        m1_readdata      = w_rdv1 ? w_resp_data : r_hold1;
        m0_err           = r_err0;
        m1_err           = r_err1;
    end

    // Capture returned data so each master's readdata holds between pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold0 <= '0;
            r_hold1 <= '0;
        end else begin
            if (w_rdv0) begin
                r_hold0 <= w_resp_data;
            end
            if (w_rdv1) begin
                r_hold1 <= w_resp_data;
            end
        end
    end

    // Sticky error flags; clear wins over a same-cycle set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
        end else if (err_clear) begin
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
        end else begin
            if (w_set_err0) begin
                r_err0 <= 1'b1;
            end
            if (w_set_err1) begin
                r_err1 <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_avalon_verin_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_verin_ram_arbiter
// Description : Directed self-checking bench for avalon_verin_ram_arbiter,
//               with a behavioural 5120x32 RAM (registered read data).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_verin_ram_arbiter;

    localparam int c_addr_w = 13;
    localparam int c_data_w = 32;
    localparam int c_depth  = 5120;

    logic                clk = 1'b0;
    logic                reset;
    logic [12:0]         m0_address, m1_address;
    logic [3:0]          m0_byteenable, m1_byteenable;
    logic                m0_read, m1_read, m0_write, m1_write;
    logic [31:0]         m0_writedata, m1_writedata;
    logic                m0_waitrequest, m1_waitrequest;
    logic [31:0]         m0_readdata, m1_readdata;
    logic                m0_readdatavalid, m1_readdatavalid;
    logic                m0_err, m1_err;
    logic                err_clear;
    logic [12:0]         ram_address;
    logic [3:0]          ram_byteenable;
    logic                ram_chipselect, ram_write;
    logic [31:0]         ram_writedata;
    logic [31:0]         ram_readdata;

    logic [31:0]         mem [0:c_depth-1];

    int                  n_checks = 0;
    int                  n_fail   = 0;

    always #5 clk = ~clk;

    avalon_verin_ram_arbiter #(
        .ADDR_W (c_addr_w),
        .DATA_W (c_data_w),
        .DEPTH  (c_depth)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m0_err           (m0_err),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .m1_err           (m1_err),
        .err_clear        (err_clear),
        .ram_address      (ram_address),
        .ram_byteenable   (ram_byteenable),
        .ram_chipselect   (ram_chipselect),
        .ram_write        (ram_write),
        .ram_writedata    (ram_writedata),
        .ram_readdata     (ram_readdata)
    );

    // Behavioural single-port RAM: byte-lane writes, read data one cycle later
    always @(posedge clk) begin
        if (ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
                end
            end else begin
                ram_readdata <= mem[ram_address];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m0(input logic rd, input logic wr, input logic [12:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    endtask

    task automatic drive_m1(input logic rd, input logic wr, input logic [12:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    endtask

    task automatic idle();
        drive_m0(1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        drive_m1(1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
    endtask

    initial begin
        for (int i = 0; i < c_depth; i++) mem[i] = 32'h0;
        ram_readdata = 32'h0;
        reset = 1'b1;
        err_clear = 1'b0;
        idle();
        tick(); tick();
        reset = 1'b0;
        #3;
        check("rst_rdv0",  {31'b0, m0_readdatavalid}, 32'd0);
        check("rst_rdv1",  {31'b0, m1_readdatavalid}, 32'd0);
        check("rst_rd0",   m0_readdata, 32'h0);
        check("rst_rd1",   m1_readdata, 32'h0);
        check("rst_err0",  {31'b0, m0_err}, 32'd0);
        check("rst_err1",  {31'b0, m1_err}, 32'd0);
        check("idle_cs",   {31'b0, ram_chipselect}, 32'd0);

        // Simultaneous writes: m0 first, m1 next cycle
        tick();
        drive_m0(1'b0, 1'b1, 13'h10, 32'hA5A5_A5A5, 4'hF);
        drive_m1(1'b0, 1'b1, 13'h11, 32'h5A5A_5A5A, 4'hF);
        #3;
        check("wr_tie_wait0", {31'b0, m0_waitrequest}, 32'd0);
        check("wr_tie_wait1", {31'b0, m1_waitrequest}, 32'd1);
        check("wr_tie_addr",  {19'b0, ram_address}, 32'h10);
        check("wr_tie_cs",    {31'b0, ram_chipselect}, 32'd1);
        tick();
        drive_m0(1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        #3;
        check("wr_m1_wait1", {31'b0, m1_waitrequest}, 32'd0);
        check("wr_m1_addr",  {19'b0, ram_address}, 32'h11);
        check("wr_m1_wen",   {31'b0, ram_write}, 32'd1);
        tick();
        // Readback tie: last_grant is m1, so m0 wins
        drive_m0(1'b1, 1'b0, 13'h10, 32'h0, 4'h0);
        drive_m1(1'b1, 1'b0, 13'h11, 32'h0, 4'h0);
        #3;
        check("rd_tie_wait0", {31'b0, m0_waitrequest}, 32'd0);
        check("rd_tie_wait1", {31'b0, m1_waitrequest}, 32'd1);
        tick();
        drive_m0(1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
        #3;
        check("rb0_rdv",  {31'b0, m0_readdatavalid}, 32'd1);
        check("rb0_data", m0_readdata, 32'hA5A5_A5A5);
        check("rb0_rdv1", {31'b0, m1_readdatavalid}, 32'd0);
        check("rb1_wait", {31'b0, m1_waitrequest}, 32'd0);
        tick();
        idle();
        #3;
        check("rb1_rdv",  {31'b0, m1_readdatavalid}, 32'd1);
        check("rb1_data", m1_readdata, 32'h5A5A_5A5A);

        // Continuous reads from both masters: strict alternation starting at m0
        tick();
        drive_m0(1'b1, 1'b0, 13'h10, 32'h0, 4'h0);
        drive_m1(1'b1, 1'b0, 13'h11, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            #3;
            check($sformatf("rr_wait0_%0d", i), {31'b0, m0_waitrequest}, (i % 2 == 0) ? 32'd0 : 32'd1);
            check($sformatf("rr_wait1_%0d", i), {31'b0, m1_waitrequest}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i > 0) begin
                check($sformatf("rr_rdv0_%0d", i), {31'b0, m0_readdatavalid}, (i % 2 == 1) ? 32'd1 : 32'd0);
                check($sformatf("rr_rdv1_%0d", i), {31'b0, m1_readdatavalid}, (i % 2 == 0) ? 32'd1 : 32'd0);
                if (i % 2 == 1) check($sformatf("rr_data0_%0d", i), m0_readdata, 32'hA5A5_A5A5);
                else            check($sformatf("rr_data1_%0d", i), m1_readdata, 32'h5A5A_5A5A);
            end
            tick();
        end
        idle();
        #3;
        check("rr_last_rdv1", {31'b0, m1_readdatavalid}, 32'd1);
        check("rr_last_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
        check("rr_last_data", m1_readdata, 32'h5A5A_5A5A);

        // Partial byte-lane write at the top word
        tick();
        drive_m1(1'b0, 1'b1, 13'd5119, 32'hFFFF_FFFF, 4'hF);
        tick();
        drive_m1(1'b0, 1'b1, 13'd5119, 32'h1234_5678, 4'b0011);
        tick();
        drive_m1(1'b1, 1'b0, 13'd5119, 32'h0, 4'h0);
        tick();
        idle();
        #3;
        check("be_rdv",  {31'b0, m1_readdatavalid}, 32'd1);
        check("be_data", m1_readdata, 32'hFFFF_5678);

        // Out-of-range read returns zero and flags m0
        tick();
        drive_m0(1'b1, 1'b0, 13'd5120, 32'h0, 4'h0);
        #3;
        check("oor_wait", {31'b0, m0_waitrequest}, 32'd0);
        check("oor_cs",   {31'b0, ram_chipselect}, 32'd0);
        tick();
        drive_m0(1'b0, 1'b1, 13'd6000, 32'hDEAD_BEEF, 4'hF);
        #3;
        check("oor_rdv",   {31'b0, m0_readdatavalid}, 32'd1);
        check("oor_data",  m0_readdata, 32'h0);
        check("oor_err0",  {31'b0, m0_err}, 32'd1);
        check("oor_err1",  {31'b0, m1_err}, 32'd0);
        check("oorw_cs",   {31'b0, ram_chipselect}, 32'd0);
        check("oorw_wait", {31'b0, m0_waitrequest}, 32'd0);
        tick();
        idle();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        #3;
        check("clr_err0", {31'b0, m0_err}, 32'd0);
        // clear in the same cycle as a new error: clear wins
        tick();
        drive_m0(1'b1, 1'b0, 13'd5120, 32'h0, 4'h0);
        err_clear = 1'b1;
        tick();
        idle();
        err_clear = 1'b0;
        #3;
        check("clr_prio_err0", {31'b0, m0_err}, 32'd0);
        // top word untouched by the out-of-range write
        tick();
        drive_m0(1'b1, 1'b0, 13'd5119, 32'h0, 4'h0);
        tick();
        idle();
        #3;
        check("oorw_ram", m0_readdata, 32'hFFFF_5678);

        // Read and write together: write done, read dropped, error set
        tick();
        drive_m0(1'b1, 1'b1, 13'd3, 32'h0000_0001, 4'hF);
        #3;
        check("rw_cs",  {31'b0, ram_chipselect}, 32'd1);
        check("rw_wen", {31'b0, ram_write}, 32'd1);
        tick();
        idle();
        #3;
        check("rw_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
        check("rw_err0", {31'b0, m0_err}, 32'd1);
        check("rw_err1", {31'b0, m1_err}, 32'd0);
        tick();
        drive_m0(1'b1, 1'b0, 13'd3, 32'h0, 4'h0);
        tick();
        idle();
        #3;
        check("rw_rb", m0_readdata, 32'h0000_0001);

        // Reset right after an accepted read
        tick();
        drive_m0(1'b1, 1'b0, 13'h10, 32'h0, 4'h0);
        tick();
        idle();
        m1_read = 1'b1;
        reset = 1'b1;
        #3;
        check("mrst_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
        check("mrst_rdv1", {31'b0, m1_readdatavalid}, 32'd0);
        check("mrst_cs",   {31'b0, ram_chipselect}, 32'd0);
        tick();
        idle();
        #3;
        check("mrst_rd0",  m0_readdata, 32'h0);
        check("mrst_rd1",  m1_readdata, 32'h0);
        check("mrst_err0", {31'b0, m0_err}, 32'd0);
        tick();
        reset = 1'b0;
        drive_m0(1'b1, 1'b0, 13'h10, 32'h0, 4'h0);
        drive_m1(1'b1, 1'b0, 13'h11, 32'h0, 4'h0);
        #3;
        check("mrst_tie_wait0", {31'b0, m0_waitrequest}, 32'd0);
        check("mrst_tie_wait1", {31'b0, m1_waitrequest}, 32'd1);
        tick();
        idle();
        #3;
        check("mrst_tie_rdv0", {31'b0, m0_readdatavalid}, 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
